// File: rtl/tmds_channel_decoder.sv
// TMDS lane receive stage: hunts for control tokens to align deserialized words (bitslip), then decodes pixel/control.
// Define TMDS_SLIP_STATS_EN to add the slip_count and lock_lost status outputs.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_SEARCH | looking for CTRL_RUN consecutive tokens; slip after SEARCH_LEN
// S_SLIP   | bitslip issued, waiting SLIP_WAIT clk cycles for the deserializer
// S_LOCKED | aligned, decoding; drops lock after LOSS_LEN words without a token
module tmds_channel_decoder #(
    parameter int SEARCH_LEN = 1024,
    parameter int SLIP_WAIT  = 8,
    parameter int CTRL_RUN   = 8,
    parameter int LOSS_LEN   = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  in_data,
    input  logic        in_valid,
    output logic        bitslip,
    output logic        locked,
    output logic [7:0]  out_data,
    output logic [1:0]  out_ctrl,
    output logic        out_de,
    output logic        out_valid
`ifdef TMDS_SLIP_STATS_EN
    ,
    output logic [15:0] slip_count,
    output logic        lock_lost
`endif
);

    localparam int GAP_MAX = (SEARCH_LEN > LOSS_LEN) ? SEARCH_LEN : LOSS_LEN;
    localparam int GW      = $clog2(GAP_MAX + 1);
    localparam int RW      = $clog2(CTRL_RUN + 1);
    localparam int WW      = $clog2(SLIP_WAIT + 1);

    localparam logic [1:0] S_SEARCH = 2'd0;
    localparam logic [1:0] S_SLIP   = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    localparam logic [GW-1:0] C_SEARCH = GW'(SEARCH_LEN);
    localparam logic [GW-1:0] C_LOSS   = GW'(LOSS_LEN);
    localparam logic [RW-1:0] C_RUN    = RW'(CTRL_RUN);
    localparam logic [WW-1:0] C_WAIT   = WW'(SLIP_WAIT - 1);

    logic [1:0]    r_state;
    logic [RW-1:0] r_run_cnt;
    logic [GW-1:0] r_gap_cnt;
    logic [WW-1:0] r_wait_cnt;
    logic          r_bitslip;
    logic [7:0]    r_out_data;
    logic [1:0]    r_out_ctrl;
    logic          r_out_de;
    logic          r_out_valid;

    logic          w_is_token;
    logic [1:0]    w_tok_code;
    logic [7:0]    w_d;
    logic [7:0]    w_pix;
    logic [RW-1:0] w_run_inc;
    logic [GW-1:0] w_gap_inc;
    logic          w_lock_now;
    logic          w_slip_now;
    logic          w_loss_now;
    logic          w_dec_en;

    always_comb begin
        w_is_token = 1'b1;
        w_tok_code = 2'b00;
        case (in_data)
            10'h354: w_tok_code = 2'b00;
            10'h0AB: w_tok_code = 2'b01;
            10'h154: w_tok_code = 2'b10;
            10'h2AB: w_tok_code = 2'b11;
            default: w_is_token = 1'b0;
        endcase
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    assign w_d   = in_data[9] ? ~in_data[7:0] : in_data[7:0];
    assign w_pix = {(in_data[8] ? (w_d[7:1] ^ w_d[6:0]) : ~(w_d[7:1] ^ w_d[6:0])), w_d[0]};

    assign w_run_inc  = r_run_cnt + 1'b1;
    assign w_gap_inc  = r_gap_cnt + 1'b1;
    assign w_lock_now = (r_state == S_SEARCH) && in_valid && w_is_token && (w_run_inc == C_RUN);
    assign w_slip_now = (r_state == S_SEARCH) && in_valid && !w_is_token && (w_gap_inc == C_SEARCH);
    assign w_loss_now = (r_state == S_LOCKED) && in_valid && !w_is_token && (w_gap_inc == C_LOSS);
    // The token that completes lock is already decoded.
    assign w_dec_en   = in_valid && ((r_state == S_LOCKED) || w_lock_now);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_SEARCH;
            r_run_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_wait_cnt <= '0;
            r_bitslip  <= 1'b0;
        end else begin
            r_bitslip <= 1'b0;
            case (r_state)
                S_SEARCH: begin
                    if (in_valid) begin
                        if (w_is_token) begin
                            r_gap_cnt <= '0;
                            if (w_lock_now) begin
                                r_run_cnt <= '0;
                                r_state   <= S_LOCKED;
                            end else begin
                                r_run_cnt <= w_run_inc;
                            end
                        end else begin
                            r_run_cnt <= '0;
                            if (w_slip_now) begin
                                r_gap_cnt  <= '0;
                                r_bitslip  <= 1'b1;
                                r_wait_cnt <= C_WAIT;
                                r_state    <= S_SLIP;
                            end else begin
                                r_gap_cnt <= w_gap_inc;
                            end
                        end
                    end
                end
                S_SLIP: begin
                    if (r_wait_cnt == '0) begin
                        r_run_cnt <= '0;
                        r_gap_cnt <= '0;
                        r_state   <= S_SEARCH;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (in_valid) begin
                        if (w_is_token) begin
                            r_gap_cnt <= '0;
                        end else if (w_loss_now) begin
                            r_gap_cnt <= '0;
                            r_run_cnt <= '0;
                            r_state   <= S_SEARCH;
                        end else begin
                            r_gap_cnt <= w_gap_inc;
                        end
                    end
                end
                default: begin
                    r_run_cnt <= '0;
                    r_gap_cnt <= '0;
                    r_state   <= S_SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_de    <= 1'b0;
            r_out_ctrl  <= 2'b00;
            r_out_data  <= 8'h00;
        end else begin
            r_out_valid <= w_dec_en;
            if (w_dec_en) begin
                if (w_is_token) begin
                    r_out_de   <= 1'b0;
                    r_out_ctrl <= w_tok_code;
                    r_out_data <= 8'h00;
                end else begin
                    r_out_de   <= 1'b1;
                    r_out_data <= w_pix;
                end
            end
        end
    end

`ifdef TMDS_SLIP_STATS_EN
    logic [15:0] r_slip_count;
    logic        r_lock_lost;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slip_count <= 16'h0000;
            r_lock_lost  <= 1'b0;
        end else begin
            if (w_slip_now && (r_slip_count != 16'hFFFF)) begin
                r_slip_count <= r_slip_count + 16'h0001;
            end
            if (w_loss_now) begin
                r_lock_lost <= 1'b1;
            end
        end
    end

    assign slip_count = r_slip_count;
    assign lock_lost  = r_lock_lost;
`endif

    assign bitslip   = r_bitslip;
    assign locked    = (r_state == S_LOCKED);
    assign out_data  = r_out_data;
    assign out_ctrl  = r_out_ctrl;
    assign out_de    = r_out_de;
    assign out_valid = r_out_valid;

endmodule
